// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetch entries; synchronous flush wins over push/pop, head is combinational.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    entries_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = entries_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && do_push) entries_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// MIPS fetch front end: byte-addressed instruction memory, fetch PC and prefetch queue.
// Optional saturating fetch/redirect counters are built when FETCH_STATS_EN is defined.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES  = 256,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_word,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_redirects
`endif
);

    localparam int AW = $clog2(IMEM_BYTES);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [7:0]    mem [IMEM_BYTES];
    logic [31:0]   fpc_q, fpc_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [31:0]   fetch_word;
    logic          deq, enq;
    fetch_entry_t  head, push_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          unused_bits;

    assign unused_bits = ^{load_addr[31:AW], fifo_count};

    assign rd_idx     = fpc_q[AW-1:0];
    assign wr_idx     = load_addr[AW-1:0] & ~AW'(3);
    assign fetch_word = {mem[rd_idx], mem[rd_idx + AW'(1)],
                         mem[rd_idx + AW'(2)], mem[rd_idx + AW'(3)]};

    // Non-blocking write gives read-before-write against a same-cycle fetch.
    always_ff @(posedge clock) begin
        if (load_we) begin
            mem[wr_idx]          <= load_word[31:24];
            mem[wr_idx + AW'(1)] <= load_word[23:16];
            mem[wr_idx + AW'(2)] <= load_word[15:8];
            mem[wr_idx + AW'(3)] <= load_word[7:0];
        end
    end

    assign deq       = if_valid & id_ready & ~redirect_valid;
    assign enq       = ~reset & ~redirect_valid & ~fault_q & (~fifo_full | deq);
    assign push_data = '{pc: fpc_q, instr: fetch_word};

    fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (enq),
        .push_data (push_data),
        .pop       (deq),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        fpc_d   = fpc_q;
        fault_d = fault_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
        end else if (enq) begin
            fpc_d = fpc_q + WORD_BYTES;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fpc_q   <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            fpc_q   <= fpc_d;
            fault_q <= fault_d;
        end
    end

    assign if_valid    = ~fifo_empty;
    assign if_instr    = if_valid ? head.instr : NOP_INSTR;
    assign if_pc       = if_valid ? head.pc : 32'h0;
    assign if_pc_plus4 = if_valid ? head.pc + WORD_BYTES : 32'h0;
    assign fetch_fault = fault_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] redirects_q, redirects_d;

    always_comb begin
        fetched_d   = fetched_q;
        redirects_d = redirects_q;
        if (enq && fetched_q != '1)              fetched_d   = fetched_q + 32'd1;
        if (redirect_valid && redirects_q != '1) redirects_d = redirects_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_q   <= '0;
            redirects_q <= '0;
        end else begin
            fetched_q   <= fetched_d;
            redirects_q <= redirects_d;
        end
    end

    assign stat_fetched   = fetched_q;
    assign stat_redirects = redirects_q;
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction-fetch front end for the 5-stage MIPS pipeline.
- Holds byte-addressed instruction memory and the fetch PC, and prefetches big-endian 32-bit words into a small queue.
- Presents the queue head to the IF/ID register with a valid/ready handshake.
- Accepts branch/jump redirects from EXE, which flush the queue.

Parameters:
- IMEM_BYTES, 256: instruction memory size in bytes; power of two, at least 4.
- QUEUE_DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset; word aligned.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load_we  in  1  instruction-memory word write strobe
- load_addr  in  32  byte address of the word written; bits [1:0] ignored
- load_word  in  32  word written; stored big-endian
- redirect_valid  in  1  EXE branch taken or jump
- redirect_pc  in  32  redirect target
- id_ready  in  1  ID accepts the head this cycle; low means stall
- if_valid  out  1  queue head valid
- if_instr  out  32  head instruction
- if_pc  out  32  head instruction address
- if_pc_plus4  out  32  if_pc + 4; used as the jal link value
- fetch_fault  out  1  sticky misaligned-redirect flag

Behaviour:
- Memory map:
  - Byte array mem[IMEM_BYTES].
  - Word at address a is {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - Index is a mod IMEM_BYTES, so fetch wraps past the end of memory.
- Memory contents:
  - Not cleared by reset.
  - A load write takes effect at the clock edge.
  - A fetch of the same word in the same cycle returns the old data (read-before-write).
- Reset:
  - fpc <= RESET_PC; queue empty; fetch_fault <= 0.
  - Outputs: if_valid 0, if_instr 0, if_pc 0, if_pc_plus4 0. All outputs are zero whenever if_valid = 0.
- Enqueue:
  - Condition: not reset, not redirect_valid, not fetch_fault, and (count < QUEUE_DEPTH or deq).
  - Action: push {fpc, word(fpc)}; fpc <= fpc + 4, mod 2^32.
- Dequeue:
  - deq = if_valid & id_ready & ~redirect_valid.
  - Outputs are driven combinationally from the queue head.
- Full/empty boundaries:
  - Full and no deq: no push, fpc holds.
  - Full with deq: push and pop in the same cycle; count unchanged.
  - Empty: if_valid = 0.
- Redirect (priority over load handshake and enqueue, not over reset):
  - At the edge: queue cleared, fpc <= redirect_pc.
  - Any head handshake in that cycle is void; ID must treat it as flushed.
  - Timing: redirect sampled at edge N; if_valid = 0 during cycle N+1; entry for redirect_pc is valid after edge N+1.
  - Back-to-back redirects: the last one wins.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_fault <= 1; queue cleared; fpc <= redirect_pc.
  - Enqueue is suppressed until reset.
- Startup latency: first entry is valid one edge after reset deasserts.
- Stall: id_ready = 0 holds the head stable; prefetch continues until full.

Optional Feature:
- Macro: FETCH_STATS_EN.
- When defined, add output ports stat_fetched[31:0] and stat_redirects[31:0]:
  - Saturating counters of pushes and of accepted redirects.
  - Cleared by reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t: packed {pc[31:0], instr[31:0]}.
  - WORD_BYTES = 4.
  - NOP_INSTR = 32'h0000_0000 (sll $zero,$zero,0).
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with synchronous flush.
  - Flush has priority over push/pop.
  - Exposes count, full, empty.
  - Head visible combinationally.

Test Plan:
- Load words 0x20010005, 0x20020003, 0x00221820 at 0x0/0x4/0x8, reset, id_ready = 1 → three consecutive cycles with if_pc 0x0/0x4/0x8 and those words; if_pc_plus4 = 0x4/0x8/0xC.
- id_ready = 0 for 6 cycles after reset → if_valid = 1 and if_pc = 0x0 held; queue fills to 4 entries; raise id_ready → if_pc 0x0, 0x4, 0x8, 0xC, 0x10 with no gap.
- redirect_valid = 1, redirect_pc = 0x40, while id_ready = 1 → if_valid = 0 for one cycle, then if_pc = 0x40, word(0x40); no stale 0x4-region entries appear.
- Memory 256 bytes, redirect_pc = 0xFC → outputs 0xFC then 0x100, with instruction read from byte index 0x00.
- redirect_pc = 0x42 → fetch_fault = 1, if_valid stays 0; after reset, fetch_fault = 0 and fetch resumes at RESET_PC.
- With FETCH_STATS_EN defined, 5 pushes then 1 redirect → stat_fetched = 5, stat_redirects = 1; reset → both 0.
